// File: rtl/cond_logic.sv
// Execute-stage condition unit: decodes the condition field against the
// incoming NZCV flags and holds the architectural flag register.
module cond_logic (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] CondE,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWriteE,
    input  logic [3:0] FlagsE,
    output logic [3:0] Flags,
    output logic       CondExE
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned HALF_W = FLAG_W / 2;

    logic              n_e;
    logic              z_e;
    logic              c_e;
    logic              v_e;
    logic              cond_ex_c;
    logic              wr_nz;
    logic              wr_cv;
    logic [HALF_W-1:0] nz_d;
    logic [HALF_W-1:0] cv_d;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] flags_q;

    assign {n_e, z_e, c_e, v_e} = FlagsE;

    // Condition decode; undecoded or unknown codes fall to 0 via default.
    always_comb begin
        cond_ex_c = 1'b0;
        case (CondE)
            4'b0000: cond_ex_c = z_e;
            4'b0001: cond_ex_c = ~z_e;
            4'b0010: cond_ex_c = c_e;
            4'b0011: cond_ex_c = ~c_e;
            4'b0100: cond_ex_c = n_e;
            4'b0101: cond_ex_c = ~n_e;
            4'b0110: cond_ex_c = v_e;
            4'b0111: cond_ex_c = ~v_e;
            4'b1000: cond_ex_c = c_e & ~z_e;
            4'b1001: cond_ex_c = ~c_e | z_e;
            4'b1010: cond_ex_c = (n_e == v_e);
            4'b1011: cond_ex_c = (n_e != v_e);
            4'b1100: cond_ex_c = ~z_e & (n_e == v_e);
            4'b1101: cond_ex_c = z_e | (n_e != v_e);
            4'b1110: cond_ex_c = 1'b1;
            default: cond_ex_c = 1'b0;
        endcase
    end

    assign CondExE = cond_ex_c;

    // Each half of the register is written independently.
    always_comb begin
        wr_nz   = FlagWriteE[1] & cond_ex_c;
        wr_cv   = FlagWriteE[0] & cond_ex_c;
        nz_d    = wr_nz ? ALUFlags[3:2] : FlagsE[3:2];
        cv_d    = wr_cv ? ALUFlags[1:0] : FlagsE[1:0];
        flags_d = {nz_d, cv_d};
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            flags_q <= FLAG_W'(0);
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flags = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: scoreboard of expected CondExE and
// Flags values, compared when the DUT output becomes valid.
module tb_cond_logic;

    logic       CLK;
    logic       Reset;
    logic [3:0] CondE;
    logic [3:0] ALUFlags;
    logic [1:0] FlagWriteE;
    logic [3:0] FlagsE;
    logic [3:0] Flags;
    logic       CondExE;

    int vectors;
    int miscompares;

    logic       cond_sb[$];
    logic [3:0] flags_sb[$];

    cond_logic dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .CondE     (CondE),
        .ALUFlags  (ALUFlags),
        .FlagWriteE(FlagWriteE),
        .FlagsE    (FlagsE),
        .Flags     (Flags),
        .CondExE   (CondExE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference decode: ARM pairs share a base test, odd codes invert it.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    function automatic logic [3:0] model_flags(input logic [3:0] c, input logic [3:0] f,
                                               input logic [3:0] alu, input logic [1:0] fw);
        logic [3:0] r;
        r = f;
        if (model_cond(c, f)) begin
            if (fw[1]) r[3:2] = alu[3:2];
            if (fw[0]) r[1:0] = alu[1:0];
        end
        return r;
    endfunction

    task automatic check_cond(input string tag);
        logic exp;
        exp = cond_sb.pop_front();
        vectors++;
        assert (CondExE === exp) else begin
            miscompares++;
            $error("FAIL %s CondExE observed=%b expected=%b", tag, CondExE, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        logic [3:0] exp;
        exp = flags_sb.pop_front();
        vectors++;
        assert (Flags === exp) else begin
            miscompares++;
            $error("FAIL %s Flags observed=%b expected=%b", tag, Flags, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] fe,
                         input logic [3:0] alu, input logic [1:0] fw);
        CondE      = c;
        FlagsE     = fe;
        ALUFlags   = alu;
        FlagWriteE = fw;
    endtask

    // One clocked vector: drive at negedge, check CondExE, check Flags after the edge.
    task automatic step(input string tag, input logic [3:0] c, input logic [3:0] fe,
                        input logic [3:0] alu, input logic [1:0] fw);
        @(negedge CLK);
        drive(c, fe, alu, fw);
        #1;
        cond_sb.push_back(model_cond(c, fe));
        check_cond({tag, "_cond"});
        flags_sb.push_back(model_flags(c, fe, alu, fw));
        @(posedge CLK);
        #1;
        check_flags(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        drive(4'b1110, 4'b0000, 4'b1111, 2'b11);

        // Reset held for two edges with an active write pending
        #1;
        flags_sb.push_back(4'b0000);
        check_flags("reset_imm");
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            flags_sb.push_back(4'b0000);
            check_flags("reset_hold");
            cond_sb.push_back(1'b1);
            check_cond("reset_cond_live");
        end
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        flags_sb.push_back(4'b0000);
        check_flags("reset_release_noedge");
        @(posedge CLK);
        #1;
        flags_sb.push_back(4'b1111);
        check_flags("reset_first_edge");

        step("uncond_write", 4'b1110, 4'b0000, 4'b0101, 2'b11);
        step("partial_nz",   4'b1110, 4'b1010, 4'b0101, 2'b10);
        step("partial_cv",   4'b1110, 4'b1010, 4'b0101, 2'b01);
        step("partial_none", 4'b1110, 4'b1010, 4'b0101, 2'b00);
        step("cond_fail",    4'b0000, 4'b0000, 4'b1111, 2'b11);

        // Fixed spec expectations alongside the model
        flags_sb.push_back(4'b0000);
        check_flags("cond_fail_const");

        // Spot checks with constant expectations
        @(negedge CLK);
        drive(4'b1100, 4'b1001, 4'b0000, 2'b00); #1;
        cond_sb.push_back(1'b1); check_cond("spot_gt");
        drive(4'b1101, 4'b1000, 4'b0000, 2'b00); #1;
        cond_sb.push_back(1'b1); check_cond("spot_le");
        drive(4'b1000, 4'b0110, 4'b0000, 2'b00); #1;
        cond_sb.push_back(1'b0); check_cond("spot_hi");
        drive(4'b1111, 4'b0101, 4'b0000, 2'b00); #1;
        cond_sb.push_back(1'b0); check_cond("spot_nv");
        drive(4'b0001, 4'b0100, 4'b0000, 2'b00); #1;
        cond_sb.push_back(1'b0); check_cond("spot_ne");

        // Full condition table sweep
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                drive(4'(c), 4'(f), 4'b0000, 2'b00);
                #1;
                cond_sb.push_back(model_cond(4'(c), 4'(f)));
                check_cond("sweep");
            end
        end

        // Randomised clocked traffic through the flag register
        for (int i = 0; i < 64; i++) begin
            step("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end

        // Async reset mid-run: load 1111 then pulse Reset between edges
        step("pre_async", 4'b1110, 4'b0000, 4'b1111, 2'b11);
        flags_sb.push_back(4'b1111);
        check_flags("pre_async_const");
        @(negedge CLK);
        drive(4'b1110, 4'b0000, 4'b0110, 2'b11);
        #2;
        Reset = 1'b1;
        #1;
        flags_sb.push_back(4'b0000);
        check_flags("async_drop");
        #1;
        Reset = 1'b0;
        #0.5;
        flags_sb.push_back(4'b0000);
        check_flags("async_hold_to_edge");
        @(posedge CLK);
        #1;
        flags_sb.push_back(4'b0110);
        check_flags("async_post_edge");

        vectors++;
        assert (cond_sb.size() == 0 && flags_sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain observed=%0d/%0d expected=0/0",
                   cond_sb.size(), flags_sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
